// File: rtl/ram_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one single-port RAM.
// Data wins contention until it has taken MAX_DATA_RUN grants in a row, then fetch gets one.
module ram_arbiter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int MAX_DATA_RUN = 3
) (
   input  logic                  clk_i,
   input  logic                  rst_i,

   input  logic                  inst_req_i,
   input  logic [ADDR_WIDTH-1:0] inst_addr_i,
   output logic                  inst_gnt_o,
   output logic                  inst_rvalid_o,
   output logic [DATA_WIDTH-1:0] inst_rdata_o,

   input  logic                  data_req_i,
   input  logic                  data_we_i,
   input  logic [ADDR_WIDTH-1:0] data_addr_i,
   input  logic [DATA_WIDTH-1:0] data_wdata_i,
   output logic                  data_gnt_o,
   output logic                  data_rvalid_o,
   output logic [DATA_WIDTH-1:0] data_rdata_o,

   output logic                  ram_ce_o,
   output logic                  ram_we_o,
   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   output logic [DATA_WIDTH-1:0] ram_wdata_o,
   input  logic [DATA_WIDTH-1:0] ram_rdata_i,

   output logic                  stallreq_o
);

   localparam int CNT_BITS = ($clog2(MAX_DATA_RUN + 1) < 2) ? 2 : $clog2(MAX_DATA_RUN + 1);
   localparam logic [CNT_BITS-1:0] RUN_MAX = CNT_BITS'(MAX_DATA_RUN);

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_INST = 2'd1;
   localparam logic [1:0] OWN_DATA = 2'd2;

   logic [CNT_BITS-1:0]   run_cnt;
   logic [1:0]            resp_own;
   logic [DATA_WIDTH-1:0] inst_hold;
   logic [DATA_WIDTH-1:0] data_hold;
   logic                  run_full;
   logic                  inst_gnt;
   logic                  data_gnt;

   assign run_full = (run_cnt == RUN_MAX);

   always_comb begin
      inst_gnt = 1'b0;
      data_gnt = 1'b0;
      if (!rst_i) begin
         if (data_req_i && !(inst_req_i && run_full))
            data_gnt = 1'b1;
         else if (inst_req_i)
            inst_gnt = 1'b1;
      end
   end

   assign inst_gnt_o = inst_gnt;
   assign data_gnt_o = data_gnt;
   assign stallreq_o = !rst_i && ((inst_req_i && !inst_gnt) || (data_req_i && !data_gnt));

   always_comb begin
      ram_ce_o    = 1'b0;
      ram_we_o    = 1'b0;
      ram_addr_o  = '0;
      ram_wdata_o = '0;
      if (inst_gnt) begin
         ram_ce_o   = 1'b1;
         ram_addr_o = inst_addr_i;
      end else if (data_gnt) begin
         ram_ce_o    = 1'b1;
         ram_we_o    = data_we_i;
         ram_addr_o  = data_addr_i;
         ram_wdata_o = data_wdata_i;
      end
   end

   // The run only counts while fetch is actually waiting; any gap resets fairness.
   always_ff @(posedge clk_i) begin
      if (rst_i)
         run_cnt <= '0;
      else if (!inst_req_i || inst_gnt)
         run_cnt <= '0;
      else if (data_gnt && !run_full)
         run_cnt <= run_cnt + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         resp_own <= OWN_NONE;
      else if (inst_gnt)
         resp_own <= OWN_INST;
      else if (data_gnt && !data_we_i)
         resp_own <= OWN_DATA;
      else
         resp_own <= OWN_NONE;
   end

   // A reset landing on the response cycle swallows that response.
   assign inst_rvalid_o = (resp_own == OWN_INST) && !rst_i;
   assign data_rvalid_o = (resp_own == OWN_DATA) && !rst_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         inst_hold <= '0;
         data_hold <= '0;
      end else begin
         if (inst_rvalid_o) inst_hold <= ram_rdata_i;
         if (data_rvalid_o) data_hold <= ram_rdata_i;
      end
   end

   // RAM data is forwarded straight through on the response cycle, then held.
   always_comb begin
      inst_rdata_o = inst_hold;
      data_rdata_o = data_hold;
      if (rst_i) begin
         inst_rdata_o = '0;
         data_rdata_o = '0;
      end else begin
         if (inst_rvalid_o) inst_rdata_o = ram_rdata_i;
         if (data_rvalid_o) data_rdata_o = ram_rdata_i;
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: cycle-by-cycle vector table plus a read-response scoreboard
// fed from a behavioural single-port RAM.
module tb_ram_arbiter;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        inst_req_i, data_req_i, data_we_i;
   logic [31:0] inst_addr_i, data_addr_i, data_wdata_i;
   logic        inst_gnt_o, inst_rvalid_o, data_gnt_o, data_rvalid_o;
   logic [31:0] inst_rdata_o, data_rdata_o;
   logic        ram_ce_o, ram_we_o, stallreq_o;
   logic [31:0] ram_addr_o, ram_wdata_o;
   logic [31:0] ram_rdata_i = '0;

   always #5 clk = ~clk;

   ram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_DATA_RUN(3)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i), .inst_gnt_o(inst_gnt_o),
      .inst_rvalid_o(inst_rvalid_o), .inst_rdata_o(inst_rdata_o),
      .data_req_i(data_req_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
      .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
      .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
      .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
      .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i),
      .stallreq_o(stallreq_o)
   );

   // Behavioural RAM driven by the DUT, and the bench's own expected memory image.
   logic [31:0] ram_mem [logic [31:0]];
   logic [31:0] exp_mem [logic [31:0]];

   function automatic logic [31:0] pat(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   function automatic logic [31:0] ram_rd(input logic [31:0] a);
      if (ram_mem.exists(a)) return ram_mem[a];
      return pat(a);
   endfunction

   function automatic logic [31:0] exp_rd(input logic [31:0] a);
      if (exp_mem.exists(a)) return exp_mem[a];
      return pat(a);
   endfunction

   always @(posedge clk) begin
      if (ram_ce_o) begin
         if (ram_we_o) ram_mem[ram_addr_o] = ram_wdata_o;
         else          ram_rdata_i <= ram_rd(ram_addr_o);
      end
   end

   typedef struct {
      logic        rst, ir, dr, we;
      logic [31:0] ia, da, wd;
      logic        eig, edg, est;
   } vec_t;

   typedef struct {
      logic        is_inst;
      logic [31:0] data;
   } resp_t;

   vec_t  vecs[$];
   resp_t sb[$];
   int    errors = 0;
   int    checks = 0;
   int    cyc = 0;
   logic [31:0] last_i = '0, last_d = '0;

   function automatic vec_t mk(input logic rst, ir, dr, we, input logic [31:0] ia, da, wd,
                               input logic eig, edg, est);
      vec_t v;
      v.rst = rst; v.ir = ir; v.dr = dr; v.we = we;
      v.ia = ia; v.da = da; v.wd = wd;
      v.eig = eig; v.edg = edg; v.est = est;
      return v;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      resp_t       e;
      logic        exp_iv, exp_dv;
      logic [31:0] e_addr, e_wd;
      @(negedge clk);
      rst_i = v.rst; inst_req_i = v.ir; data_req_i = v.dr; data_we_i = v.we;
      inst_addr_i = v.ia; data_addr_i = v.da; data_wdata_i = v.wd;
      #1;
      chk("gnt_stall", {inst_gnt_o, data_gnt_o, stallreq_o}, {v.eig, v.edg, v.est});
      e_addr = v.eig ? v.ia : (v.edg ? v.da : 32'h0);
      e_wd   = (v.edg && !v.eig) ? v.wd : 32'h0;
      chk("ram_bus", {ram_ce_o, ram_we_o, ram_addr_o, ram_wdata_o},
          {v.eig | v.edg, v.edg & v.we, e_addr, e_wd});

      exp_iv = 1'b0;
      exp_dv = 1'b0;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         if (!v.rst) begin
            if (e.is_inst) begin exp_iv = 1'b1; last_i = e.data; end
            else           begin exp_dv = 1'b1; last_d = e.data; end
         end
      end
      if (v.rst) begin last_i = '0; last_d = '0; end
      chk("rvalid", {inst_rvalid_o, data_rvalid_o}, {exp_iv, exp_dv});
      chk("inst_rdata", inst_rdata_o, last_i);
      chk("data_rdata", data_rdata_o, last_d);

      if (v.eig) begin
         e.is_inst = 1'b1; e.data = exp_rd(v.ia); sb.push_back(e);
      end else if (v.edg) begin
         if (v.we) exp_mem[v.da] = v.wd;
         else begin e.is_inst = 1'b0; e.data = exp_rd(v.da); sb.push_back(e); end
      end
      cyc++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] ra, rw;
      rst_i = 1'b1; inst_req_i = 0; data_req_i = 0; data_we_i = 0;
      inst_addr_i = 0; data_addr_i = 0; data_wdata_i = 0;
      ram_mem[32'h100] = 32'hDEADBEEF;
      exp_mem[32'h100] = 32'hDEADBEEF;

      // reset with requests present: nothing granted, no stall
      vecs.push_back(mk(1,1,1,0, 32'h100, 32'h40, 0,           0,0,0));
      vecs.push_back(mk(1,0,0,0, 0, 0, 0,                      0,0,0));
      // lone fetch read, response next cycle, then held
      vecs.push_back(mk(0,1,0,0, 32'h100, 0, 0,                1,0,0));
      vecs.push_back(mk(0,0,0,0, 0, 0, 0,                      0,0,0));
      vecs.push_back(mk(0,0,0,0, 0, 0, 0,                      0,0,0));
      // continuous contention: D,D,D,I,D,D,D,I
      for (int k = 0; k < 8; k++)
         vecs.push_back(mk(0,1,1,0, 32'h104, 32'h40, 0, (k % 4) == 3, (k % 4) != 3, 1));
      // write then read-back of the same word
      vecs.push_back(mk(0,0,1,1, 0, 32'h20, 32'h12345678,      0,1,0));
      vecs.push_back(mk(0,0,1,0, 0, 32'h20, 0,                 0,1,0));
      vecs.push_back(mk(0,0,0,0, 0, 0, 0,                      0,0,0));
      // alternating ports, back to back
      vecs.push_back(mk(0,1,0,0, 32'h108, 0, 0,                1,0,0));
      vecs.push_back(mk(0,0,1,0, 0, 32'h44, 0,                 0,1,0));
      vecs.push_back(mk(0,1,0,0, 32'h10C, 0, 0,                1,0,0));
      vecs.push_back(mk(0,0,1,0, 0, 32'h48, 0,                 0,1,0));
      vecs.push_back(mk(0,0,0,0, 0, 0, 0,                      0,0,0));
      // fetch drops mid-run: run restarts, data gets three more before fetch
      vecs.push_back(mk(0,1,1,0, 32'h110, 32'h4C, 0,           0,1,1));
      vecs.push_back(mk(0,1,1,0, 32'h110, 32'h4C, 0,           0,1,1));
      vecs.push_back(mk(0,0,1,0, 0, 32'h4C, 0,                 0,1,0));
      vecs.push_back(mk(0,1,1,0, 32'h110, 32'h4C, 0,           0,1,1));
      vecs.push_back(mk(0,1,1,0, 32'h110, 32'h4C, 0,           0,1,1));
      vecs.push_back(mk(0,1,1,0, 32'h110, 32'h4C, 0,           0,1,1));
      vecs.push_back(mk(0,1,1,0, 32'h110, 32'h4C, 0,           1,0,1));
      vecs.push_back(mk(0,0,0,0, 0, 0, 0,                      0,0,0));
      // reset right after a fetch grant discards its response
      vecs.push_back(mk(0,1,0,0, 32'h100, 0, 0,                1,0,0));
      vecs.push_back(mk(1,0,0,0, 0, 0, 0,                      0,0,0));
      vecs.push_back(mk(0,0,0,0, 0, 0, 0,                      0,0,0));
      vecs.push_back(mk(0,0,0,0, 0, 0, 0,                      0,0,0));
      // reset mid-run clears the run counter
      vecs.push_back(mk(0,1,1,0, 32'h114, 32'h50, 0,           0,1,1));
      vecs.push_back(mk(0,1,1,0, 32'h114, 32'h50, 0,           0,1,1));
      vecs.push_back(mk(1,1,1,0, 32'h114, 32'h50, 0,           0,0,0));
      vecs.push_back(mk(0,1,1,0, 32'h114, 32'h50, 0,           0,1,1));
      vecs.push_back(mk(0,1,1,0, 32'h114, 32'h50, 0,           0,1,1));
      vecs.push_back(mk(0,1,1,0, 32'h114, 32'h50, 0,           0,1,1));
      vecs.push_back(mk(0,1,1,0, 32'h114, 32'h50, 0,           1,0,1));
      vecs.push_back(mk(0,0,0,0, 0, 0, 0,                      0,0,0));

      foreach (vecs[i]) apply(vecs[i]);

      // random write/read-back pairs with a lone data requester
      for (int k = 0; k < 6; k++) begin
         ra = 32'h200 + 32'(k * 4);
         rw = $urandom;
         apply(mk(0,0,1,1, 0, ra, rw, 0,1,0));
         apply(mk(0,0,1,0, 0, ra, 0,  0,1,0));
      end
      apply(mk(0,0,0,0, 0, 0, 0, 0,0,0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of all address ports.
REQ-002 Parameter DATA_WIDTH, default 32, width of all data ports.
REQ-003 Parameter MAX_DATA_RUN, default 3, max consecutive data grants while an instruction request waits.
REQ-004 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 inst_req_i  input  1  fetch port requests a read this cycle.
REQ-007 inst_addr_i  input  ADDR_WIDTH  fetch read address.
REQ-008 inst_gnt_o  output  1  fetch request accepted this cycle (combinational).
REQ-009 inst_rvalid_o  output  1  inst_rdata_o valid (registered).
REQ-010 inst_rdata_o  output  DATA_WIDTH  fetch read data.
REQ-011 data_req_i  input  1  load/store port request this cycle.
REQ-012 data_we_i  input  1  1 = write, 0 = read.
REQ-013 data_addr_i  input  ADDR_WIDTH  load/store address.
REQ-014 data_wdata_i  input  DATA_WIDTH  store data.
REQ-015 data_gnt_o  output  1  data request accepted this cycle (combinational).
REQ-016 data_rvalid_o  output  1  data_rdata_o valid; reads only (registered).
REQ-017 data_rdata_o  output  DATA_WIDTH  load data.
REQ-018 ram_ce_o / ram_we_o  output  1 / 1  single-port RAM enable / write enable.
REQ-019 ram_addr_o / ram_wdata_o  output  ADDR_WIDTH / DATA_WIDTH  RAM address / write data.
REQ-020 ram_rdata_i  input  DATA_WIDTH  RAM read data, valid one cycle after an enabled read.
REQ-021 stallreq_o  output  1  to pipe_ctrl: some request was refused this cycle.

Function
REQ-022 At most one of inst_gnt_o, data_gnt_o SHALL be high per cycle; a grant requires the matching req.
REQ-023 Arbitration: only one requester -> grant it; both -> grant data unless run_cnt == MAX_DATA_RUN, then grant inst.
REQ-024 run_cnt (2+ bits, saturating at MAX_DATA_RUN) SHALL increment on a data grant while inst_req_i is high; it SHALL clear on any inst grant or any cycle with inst_req_i low.
REQ-025 In a granted cycle, ram_ce_o = 1; ram_addr_o, ram_we_o, ram_wdata_o come from the winner; ram_we_o = 0 and ram_wdata_o = 0 for inst grants.
REQ-026 With no grant, ram_ce_o = 0, ram_we_o = 0, ram_addr_o = 0, ram_wdata_o = 0.
REQ-027 Response-owner register resp_own {NONE, INST, DATA} SHALL load INST on an inst grant, DATA on a data read grant, and NONE otherwise (including data writes).
REQ-028 Read latency is exactly 1 cycle: in cycle N+1 after a grant in cycle N, the owner's rvalid SHALL be 1 and its rdata SHALL equal ram_rdata_i.
REQ-029 rdata outputs SHALL hold their last value while rvalid is 0.
REQ-030 Back-to-back grants SHALL be allowed: a new grant in the same cycle as the previous response, with no bubble.
REQ-031 A data write SHALL complete on grant; it SHALL NOT produce data_rvalid_o.
REQ-032 stallreq_o = (inst_req_i & ~inst_gnt_o) | (data_req_i & ~data_gnt_o), combinational.
REQ-033 Requesters SHALL keep req and payload stable until granted; the arbiter stores no request state.

Reset
REQ-034 While rst_i is high: all gnt outputs, ram_ce_o, ram_we_o and stallreq_o SHALL be 0, and ram_addr_o and ram_wdata_o SHALL be 0.
REQ-035 On the first clock edge with rst_i high: run_cnt = 0, resp_own = NONE, both rvalid = 0, both rdata = 0.
REQ-036 Reset in the cycle after a grant SHALL discard that pending response: no rvalid is asserted.

Verification
REQ-037 Inst-only read of 0x100 with RAM word 0xDEADBEEF: inst_gnt_o = 1 in cycle N; inst_rvalid_o = 1 and inst_rdata_o = 0xDEADBEEF in N+1; stallreq_o = 0 throughout.
REQ-038 Both ports request continuously (data read, MAX_DATA_RUN = 3): grant sequence D,D,D,I,D,D,D,I; stallreq_o = 1 every cycle.
REQ-039 Data write to 0x20 of 0x12345678, then data read of 0x20: data_rvalid_o = 0 after the write and 1 after the read, with 0x12345678.
REQ-040 Alternating inst/data reads on consecutive cycles: each rvalid is routed to the correct port one cycle after its grant, with no cross-delivery.
REQ-041 rst_i asserted the cycle after an inst grant: no inst_rvalid_o; all outputs 0 until the next request after rst_i falls.
REQ-042 inst_req_i drops during a data run with run_cnt = 2: run_cnt = 0 the next cycle; a later contention grants data for 3 cycles before inst.
